// File: rtl/ahbl_cmd_master.sv
// ahbl_cmd_master: AHB-Lite single-master initiator fed from a valid/ready
// command port. Each command becomes one NONSEQ transfer; address and data
// phases are pipelined in two stages (A = address phase, D = data phase).
// Optional feature macro: AHBL_MASTER_STATS_EN adds stat_xfers/stat_waits.
module ahbl_cmd_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_size,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic [2:0]        HSIZE,
  output logic              HWRITE,
  output logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  input  logic [DATA_W-1:0] HRDATA,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata
`ifdef AHBL_MASTER_STATS_EN
  ,
  output logic [31:0]       stat_xfers,
  output logic [31:0]       stat_waits
`endif
);

  typedef enum logic [1:0] {
    TR_IDLE   = 2'b00,
    TR_NONSEQ = 2'b10
  } htrans_e;

  // A stage: the bus address-phase registers double as the A fields
  htrans_e           htrans_q, htrans_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic [2:0]        hsize_q, hsize_d;
  logic              hwrite_q, hwrite_d;
  logic [DATA_W-1:0] a_wdata_q, a_wdata_d;
  // D stage
  logic              d_valid_q, d_valid_d;
  logic              d_write_q, d_write_d;
  logic [DATA_W-1:0] hwdata_q, hwdata_d;
  // response
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_write_q, rsp_write_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic       a_valid;
  logic       accept;
  logic [2:0] size_clamped;

  assign a_valid      = (htrans_q == TR_NONSEQ);
  assign cmd_ready    = !a_valid || HREADY;
  assign accept       = cmd_valid && cmd_ready;
  assign size_clamped = (cmd_size > 3'd2) ? 3'b010 : cmd_size;

  assign HTRANS    = htrans_q;
  assign HADDR     = haddr_q;
  assign HSIZE     = hsize_q;
  assign HWRITE    = hwrite_q;
  assign HWDATA    = hwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;

  // Next-state for both pipeline stages and the response; HREADY low freezes A and D
  always_comb begin
    htrans_d    = htrans_q;
    haddr_d     = haddr_q;
    hsize_d     = hsize_q;
    hwrite_d    = hwrite_q;
    a_wdata_d   = a_wdata_q;
    d_valid_d   = d_valid_q;
    d_write_d   = d_write_q;
    hwdata_d    = hwdata_q;
    rsp_valid_d = 1'b0;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;

    if (HREADY) begin
      d_valid_d = a_valid;
      d_write_d = hwrite_q;
      if (a_valid && hwrite_q) begin
        hwdata_d = a_wdata_q;
      end
      if (d_valid_q) begin
        rsp_valid_d = 1'b1;
        rsp_write_d = d_write_q;
        rsp_rdata_d = d_write_q ? '0 : HRDATA;
      end
    end

    // accept overrides A completion so back-to-back commands leave no IDLE gap
    if (accept) begin
      htrans_d  = TR_NONSEQ;
      haddr_d   = cmd_addr;
      hsize_d   = size_clamped;
      hwrite_d  = cmd_write;
      a_wdata_d = cmd_wdata;
    end else if (a_valid && HREADY) begin
      htrans_d = TR_IDLE;
    end
  end

  // Pipeline and response registers; reset drops both stages at once
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      htrans_q    <= TR_IDLE;
      haddr_q     <= '0;
      hsize_q     <= 3'b010;
      hwrite_q    <= 1'b0;
      a_wdata_q   <= '0;
      d_valid_q   <= 1'b0;
      d_write_q   <= 1'b0;
      hwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      htrans_q    <= htrans_d;
      haddr_q     <= haddr_d;
      hsize_q     <= hsize_d;
      hwrite_q    <= hwrite_d;
      a_wdata_q   <= a_wdata_d;
      d_valid_q   <= d_valid_d;
      d_write_q   <= d_write_d;
      hwdata_q    <= hwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

`ifdef AHBL_MASTER_STATS_EN
  logic [31:0] stat_xfers_q, stat_waits_q;

  assign stat_xfers = stat_xfers_q;
  assign stat_waits = stat_waits_q;

  // Completed transfers and data-phase wait cycles, free-running with wrap
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      stat_xfers_q <= '0;
      stat_waits_q <= '0;
    end else begin
      if (d_valid_q && HREADY) begin
        stat_xfers_q <= stat_xfers_q + 32'd1;
      end
      if (d_valid_q && !HREADY) begin
        stat_waits_q <= stat_waits_q + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ahbl_cmd_master.sv
// Directed bench for ahbl_cmd_master with a small behavioural AHB-Lite slave.
// Inputs are driven and outputs sampled at the falling clock edge.
module tb_ahbl_cmd_master;

  logic        HCLK;
  logic        HRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        rsp_valid;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
`ifdef AHBL_MASTER_STATS_EN
  logic [31:0] stat_xfers;
  logic [31:0] stat_waits;
`endif

  int checks = 0;
  int errors = 0;

  ahbl_cmd_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE),
    .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata)
`ifdef AHBL_MASTER_STATS_EN
    , .stat_xfers(stat_xfers), .stat_waits(stat_waits)
`endif
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Behavioural slave: 16 words, data phase tracked from the captured address phase
  logic [31:0] mem [0:15];
  logic        dp_valid;
  logic        dp_write;
  logic [31:0] dp_addr;

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= 32'h0;
      mem[1]   <= 32'hCAFE_0001;
      mem[4]   <= 32'h1111_0010;
      mem[5]   <= 32'h2222_0014;
      mem[6]   <= 32'h3333_0018;
      mem[7]   <= 32'h4444_001C;
    end else if (HREADY) begin
      if (dp_valid && dp_write) mem[dp_addr[5:2]] <= HWDATA;
      dp_valid <= (HTRANS == 2'b10);
      dp_write <= HWRITE;
      dp_addr  <= HADDR;
    end
  end

  assign HRDATA = (dp_valid && !dp_write) ? mem[dp_addr[5:2]] : 32'h0;

  task automatic test_reset();
    HRESETn = 1'b0; HREADY = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = 32'h0; cmd_size = 3'd2; cmd_wdata = 32'h0;
    @(negedge HCLK); @(negedge HCLK);
    checks++; if (HTRANS !== 2'b00) begin errors++; $display("FAIL rst_htrans: got %h expected 0", HTRANS); end
    checks++; if (HADDR !== 32'h0) begin errors++; $display("FAIL rst_haddr: got %h expected 0", HADDR); end
    checks++; if (HSIZE !== 3'b010) begin errors++; $display("FAIL rst_hsize: got %h expected 2", HSIZE); end
    checks++; if (HWRITE !== 1'b0) begin errors++; $display("FAIL rst_hwrite: got %b expected 0", HWRITE); end
    checks++; if (HWDATA !== 32'h0) begin errors++; $display("FAIL rst_hwdata: got %h expected 0", HWDATA); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready: got %b expected 1", cmd_ready); end
`ifdef AHBL_MASTER_STATS_EN
    checks++; if (stat_xfers !== 32'h0 || stat_waits !== 32'h0) begin errors++; $display("FAIL rst_stats: got %h/%h expected 0/0", stat_xfers, stat_waits); end
`endif
    HRESETn = 1'b1;
    @(negedge HCLK);
  endtask

  // Single read of the register at 0x4, zero wait states
  task automatic test_read();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4; cmd_size = 3'd2;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rd_ready: got %b expected 1", cmd_ready); end
    @(negedge HCLK);
    cmd_valid = 1'b0;
    checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h4 || HWRITE !== 1'b0 || HSIZE !== 3'd2) begin errors++; $display("FAIL rd_aphase: got %h/%h/%b/%h expected 2/4/0/2", HTRANS, HADDR, HWRITE, HSIZE); end
    @(negedge HCLK);
    checks++; if (HTRANS !== 2'b00 || HADDR !== 32'h4) begin errors++; $display("FAIL rd_idle: got %h/%h expected 0/4", HTRANS, HADDR); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_early_rsp: got %b expected 0", rsp_valid); end
    @(negedge HCLK);
    checks++; if (rsp_valid !== 1'b1 || rsp_write !== 1'b0 || rsp_rdata !== 32'hCAFE_0001) begin errors++; $display("FAIL rd_rsp: got %b/%b/%h expected 1/0/cafe0001", rsp_valid, rsp_write, rsp_rdata); end
    @(negedge HCLK);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_rsp_pulse: got %b expected 0", rsp_valid); end
  endtask

  // Write then immediately read the same word back
  task automatic test_write_readback();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0; cmd_wdata = 32'h1234_5678; cmd_size = 3'd2;
    @(negedge HCLK);
    checks++; if (HTRANS !== 2'b10 || HWRITE !== 1'b1 || HADDR !== 32'h0) begin errors++; $display("FAIL wr_aphase: got %h/%b/%h expected 2/1/0", HTRANS, HWRITE, HADDR); end
    cmd_write = 1'b0; cmd_wdata = 32'h0;
    @(negedge HCLK);
    cmd_valid = 1'b0;
    checks++; if (HWDATA !== 32'h1234_5678) begin errors++; $display("FAIL wr_hwdata: got %h expected 12345678", HWDATA); end
    checks++; if (HTRANS !== 2'b10 || HWRITE !== 1'b0) begin errors++; $display("FAIL wr_rd_b2b: got %h/%b expected 2/0", HTRANS, HWRITE); end
    @(negedge HCLK);
    checks++; if (rsp_valid !== 1'b1 || rsp_write !== 1'b1 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL wr_rsp: got %b/%b/%h expected 1/1/0", rsp_valid, rsp_write, rsp_rdata); end
    checks++; if (HWDATA !== 32'h1234_5678) begin errors++; $display("FAIL wr_hwdata_keep: got %h expected 12345678", HWDATA); end
    @(negedge HCLK);
    checks++; if (rsp_valid !== 1'b1 || rsp_write !== 1'b0 || rsp_rdata !== 32'h1234_5678) begin errors++; $display("FAIL rb_rsp: got %b/%b/%h expected 1/0/12345678", rsp_valid, rsp_write, rsp_rdata); end
    @(negedge HCLK);
  endtask

  // Four reads with cmd_valid held high
  task automatic test_back_to_back();
    logic [31:0] addrs [4];
    logic [31:0] exp_d [4];
    addrs = '{32'h10, 32'h14, 32'h18, 32'h1C};
    exp_d = '{32'h1111_0010, 32'h2222_0014, 32'h3333_0018, 32'h4444_001C};
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = addrs[0]; cmd_size = 3'd2;
    for (int c = 1; c <= 7; c++) begin
      @(negedge HCLK);
      if (c <= 4) begin
        checks++; if (HTRANS !== 2'b10 || HADDR !== addrs[c-1]) begin errors++; $display("FAIL b2b_aphase%0d: got %h/%h expected 2/%h", c, HTRANS, HADDR, addrs[c-1]); end
      end else begin
        checks++; if (HTRANS !== 2'b00) begin errors++; $display("FAIL b2b_idle%0d: got %h expected 0", c, HTRANS); end
      end
      if (c >= 3 && c <= 6) begin
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== exp_d[c-3]) begin errors++; $display("FAIL b2b_rsp%0d: got %b/%h expected 1/%h", c, rsp_valid, rsp_rdata, exp_d[c-3]); end
      end else begin
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_norsp%0d: got %b expected 0", c, rsp_valid); end
      end
      if (c < 4) cmd_addr = addrs[c];
      else cmd_valid = 1'b0;
    end
  endtask

  // Write data phase stretched by three wait states with a read pending in A
  task automatic test_wait_states();
`ifdef AHBL_MASTER_STATS_EN
    logic [31:0] x0, w0;
`endif
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h8; cmd_wdata = 32'hDEAD_BEEF; cmd_size = 3'd2;
    @(negedge HCLK);
`ifdef AHBL_MASTER_STATS_EN
    x0 = stat_xfers; w0 = stat_waits;
`endif
    cmd_write = 1'b0; cmd_wdata = 32'h0;
    @(negedge HCLK);
    HREADY = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL ws_ready0: got %b expected 0", cmd_ready); end
    for (int c = 0; c < 3; c++) begin
      @(negedge HCLK);
      checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h8 || HWDATA !== 32'hDEAD_BEEF || HWRITE !== 1'b0) begin errors++; $display("FAIL ws_hold%0d: got %h/%h/%h/%b expected 2/8/deadbeef/0", c, HTRANS, HADDR, HWDATA, HWRITE); end
      checks++; if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL ws_stall%0d: got ready %b rsp %b expected 0/0", c, cmd_ready, rsp_valid); end
    end
    HREADY = 1'b1; cmd_valid = 1'b0;
    @(negedge HCLK);
    checks++; if (rsp_valid !== 1'b1 || rsp_write !== 1'b1) begin errors++; $display("FAIL ws_rsp: got %b/%b expected 1/1", rsp_valid, rsp_write); end
`ifdef AHBL_MASTER_STATS_EN
    checks++; if (stat_waits - w0 !== 32'd3 || stat_xfers - x0 !== 32'd1) begin errors++; $display("FAIL ws_stats: got waits %0d xfers %0d expected 3/1", stat_waits - w0, stat_xfers - x0); end
`endif
    @(negedge HCLK);
    checks++; if (rsp_valid !== 1'b1 || rsp_write !== 1'b0 || rsp_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ws_rd_rsp: got %b/%b/%h expected 1/0/deadbeef", rsp_valid, rsp_write, rsp_rdata); end
    @(negedge HCLK);
  endtask

  // Reset while both A and D hold transfers
  task automatic test_reset_mid();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4; cmd_size = 3'd2;
    @(negedge HCLK);
    cmd_addr = 32'h10;
    @(negedge HCLK);
    cmd_valid = 1'b0;
    checks++; if (HTRANS !== 2'b10) begin errors++; $display("FAIL rm_pre: got %h expected 2", HTRANS); end
    HRESETn = 1'b0;
    #1;
    checks++; if (HTRANS !== 2'b00 || HADDR !== 32'h0) begin errors++; $display("FAIL rm_async: got %h/%h expected 0/0", HTRANS, HADDR); end
    @(negedge HCLK);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_rsp_in_rst: got %b expected 0", rsp_valid); end
    @(negedge HCLK);
    HRESETn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge HCLK);
      checks++; if (rsp_valid !== 1'b0 || HTRANS !== 2'b00 || cmd_ready !== 1'b1) begin errors++; $display("FAIL rm_after%0d: got rsp %b htrans %h ready %b expected 0/0/1", c, rsp_valid, HTRANS, cmd_ready); end
    end
  endtask

  // Size clamp and unaligned address pass-through
  task automatic test_size_clamp();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4; cmd_size = 3'd1;
    @(negedge HCLK);
    checks++; if (HSIZE !== 3'd1) begin errors++; $display("FAIL sz_half: got %h expected 1", HSIZE); end
    cmd_size = 3'b111; cmd_addr = 32'h5;
    @(negedge HCLK);
    cmd_valid = 1'b0;
    checks++; if (HSIZE !== 3'b010 || HADDR !== 32'h5) begin errors++; $display("FAIL sz_clamp: got %h/%h expected 2/5", HSIZE, HADDR); end
    @(negedge HCLK); @(negedge HCLK); @(negedge HCLK);
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_readback();
    test_back_to_back();
    test_wait_states();
    test_reset_mid();
    test_size_clamp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
